// File: rtl/timer_pkg.sv
// Package timer_pkg
// Shared definitions for the countdown timer chain (tick controller and digit
// counters): the tick-controller state encoding and the clock divider helper.
package timer_pkg;

    // Tick-controller state codes; 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } tick_state_t;

    // Number of clk cycles per tick period.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned hz);
        return clk_hz / hz;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Module btn_conditioner
// Turns a raw asynchronous button level into a single-cycle request pulse:
// 2-FF synchroniser, DEB_CYCLES stable-level debounce, rising-edge detect.
// Only compiled when TIMER_BTN_CONDITION_EN is defined.
// Ports:
//   clk    clock
//   rst    synchronous active-low reset
//   btn_i  raw button level (asynchronous)
//   req_o  one-cycle request on a debounced rising edge
`ifdef TIMER_BTN_CONDITION_EN
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic req_o
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Debounce: the stable level follows the synchronised level only after it
    // has differed for DEB_CYCLES consecutive samples; any agreement restarts.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, debounce and edge-detect state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // Both terms are registers, so the pulse is glitch-free.
    assign req_o = deb_q & ~deb_prev_q;

endmodule
`endif

// File: rtl/countdown_tick_ctrl.sv
// Module countdown_tick_ctrl
// Upstream control of the countdown timer chain: divides clk down to a
// one-cycle decrement tick and sequences load / run / pause / expire.
// Optional macro TIMER_BTN_CONDITION_EN: start_i, pause_i and load_i are raw
// button levels conditioned by btn_conditioner; otherwise they are
// clk-synchronous single-cycle pulses used directly.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start_i       start request
//   pause_i       pause/resume toggle request
//   load_i        load-switch-value request
//   time_out_i    one-cycle pulse from the MS digit: count exhausted
//   tick_o        one-cycle decrement tick to the digit chain
//   reconfig_o    digit load enable
//   running_o     high in RUN
//   expired_o     high in EXPIRED
//   state_o       encoded FSM state (debug/LEDs)
module countdown_tick_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned TICK_HZ     = 10,
    parameter int unsigned LOAD_CYCLES = 2
`ifdef TIMER_BTN_CONDITION_EN
,   parameter int unsigned DEB_CYCLES  = 500_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       load_i,
    input  logic       time_out_i,
    output logic       tick_o,
    output logic       reconfig_o,
    output logic       running_o,
    output logic       expired_o,
    output logic [2:0] state_o
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, TICK_HZ);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned LW  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_CYCLES - 1);

    logic start_req_s, pause_req_s, load_req_s;

`ifdef TIMER_BTN_CONDITION_EN
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start_cond (
        .clk(clk), .rst(rst), .btn_i(start_i), .req_o(start_req_s));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_pause_cond (
        .clk(clk), .rst(rst), .btn_i(pause_i), .req_o(pause_req_s));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_load_cond (
        .clk(clk), .rst(rst), .btn_i(load_i), .req_o(load_req_s));
`else
    assign start_req_s = start_i;
    assign pause_req_s = pause_i;
    assign load_req_s  = load_i;
`endif

    tick_state_t   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic          tick_q, tick_d;
    logic          reconfig_q, running_q, expired_q;

    // Next-state, prescaler and load-counter logic.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        load_cnt_d = load_cnt_q;
        tick_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_req_s) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else if (start_req_s) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Expiry suppresses the tick even on a terminal count; pausing
                // freezes the prescaler so resume continues the same period.
                if (time_out_i) begin
                    state_d = ST_EXPIRED;
                end else if (pause_req_s) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (pause_req_s) begin
                    state_d = ST_RUN;
                end else if (load_req_s) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_EXPIRED: begin
                if (load_req_s) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end else begin
                    state_d = ST_EXPIRED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; flags decode the next state so they align
    // with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            load_cnt_q <= '0;
            tick_q     <= 1'b0;
            reconfig_q <= 1'b0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            load_cnt_q <= load_cnt_d;
            tick_q     <= tick_d;
            reconfig_q <= (state_d == ST_LOAD);
            running_q  <= (state_d == ST_RUN);
            expired_q  <= (state_d == ST_EXPIRED);
        end
    end

    assign tick_o     = tick_q;
    assign reconfig_o = reconfig_q;
    assign running_o  = running_q;
    assign expired_o  = expired_q;
    assign state_o    = state_q;

endmodule
